// File: rtl/emulib_ingress_pipe_fifo_if.sv
// Host/model bundle for the ingress pipe FIFO: host push/commit/flush/hold
// controls, occupancy counters and the model-facing pio stream.
interface emulib_ingress_pipe_fifo_if #(
    parameter int DATA_WIDTH = 1,
    parameter int CNT_WIDTH  = 5
);
    // Handshakes: a push happens on a cycle where host_valid && host_ready are
    // both high; a stream response is consumed on a cycle where stream_valid &&
    // stream_ready are both high, and it pops a word only if stream_empty is low.
    logic                  host_valid;
    logic                  host_ready;
    logic [DATA_WIDTH-1:0] host_data;
    logic                  host_commit;
    logic                  host_flush;
    logic                  host_hold;
    logic [CNT_WIDTH-1:0]  staged_count;
    logic [CNT_WIDTH-1:0]  committed_count;
    logic [31:0]           consumed_total;
    logic                  stream_valid;
    logic [DATA_WIDTH-1:0] stream_data;
    logic                  stream_empty;
    logic                  stream_ready;

    modport master (
        output host_valid, host_data, host_commit, host_flush, host_hold, stream_ready,
        input  host_ready, staged_count, committed_count, consumed_total,
               stream_valid, stream_data, stream_empty
    );

    modport slave (
        input  host_valid, host_data, host_commit, host_flush, host_hold, stream_ready,
        output host_ready, staged_count, committed_count, consumed_total,
               stream_valid, stream_data, stream_empty
    );
endinterface

// File: rtl/emulib_ingress_pipe_fifo.sv
// Staging FIFO: host words become visible to the model only after a commit
// pulse, so the model always sees whole batches.
module emulib_ingress_pipe_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input logic                       clk,
    input logic                       rst,
    emulib_ingress_pipe_fifo_if.slave bus
);
    localparam int ADDR = $clog2(DEPTH);
    localparam int PW   = ADDR + 1;
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [31:0]           consumed_q, consumed_d;
    logic                  stream_valid_q;
    logic [PW-1:0]         staged_cnt;
    logic [PW-1:0]         committed_cnt;
    logic                  host_ready;
    logic                  push;
    logic                  pop;
    logic                  empty;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign staged_cnt    = wr_ptr_q - rd_ptr_q;
    assign committed_cnt = cm_ptr_q - rd_ptr_q;
    assign empty         = (cm_ptr_q == rd_ptr_q);
    assign host_ready    = (staged_cnt != FULL_CNT) && !bus.host_flush;
    assign push          = bus.host_valid && host_ready;
    assign pop           = stream_valid_q && bus.stream_ready && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        cm_ptr_d   = bus.host_commit ? wr_ptr_d : cm_ptr_q;
        consumed_d = consumed_q + 32'(pop);
        if (bus.host_flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cm_ptr_d   = '0;
            consumed_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            cm_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            consumed_q     <= '0;
            stream_valid_q <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            cm_ptr_q       <= cm_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            consumed_q     <= consumed_d;
            stream_valid_q <= !bus.host_hold;
        end
    end

    // Storage is left uninitialised; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR-1:0]] <= bus.host_data;
        end
    end

    assign bus.host_ready      = host_ready;
    assign bus.staged_count    = CNT_WIDTH'(staged_cnt);
    assign bus.committed_count = CNT_WIDTH'(committed_cnt);
    assign bus.consumed_total  = consumed_q;
    assign bus.stream_valid    = stream_valid_q;
    assign bus.stream_data     = mem_q[rd_ptr_q[ADDR-1:0]];
    assign bus.stream_empty    = empty;
endmodule

// File: tb/tb_emulib_ingress_pipe_fifo.sv
// Directed table-driven bench for the ingress pipe FIFO (8-bit words, depth 4).
module tb_emulib_ingress_pipe_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          c;
    logic          f;
    logic          h;
    logic          r;
    logic          e_hr;
    logic [CW-1:0] e_stg;
    logic [CW-1:0] e_cm;
    logic [31:0]   e_cons;
    logic          e_sv;
    logic          e_se;
    logic          e_chk;
    logic [DW-1:0] e_sd;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  vec_t vecs[$];

  emulib_ingress_pipe_fifo_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  emulib_ingress_pipe_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic v, logic [DW-1:0] d, logic c, logic f, logic h, logic r,
                              logic hr, logic [CW-1:0] stg, logic [CW-1:0] cm,
                              logic [31:0] cons, logic sv, logic se, logic chk,
                              logic [DW-1:0] sd);
    vec_t x;
    x.v = v; x.d = d; x.c = c; x.f = f; x.h = h; x.r = r;
    x.e_hr = hr; x.e_stg = stg; x.e_cm = cm; x.e_cons = cons;
    x.e_sv = sv; x.e_se = se; x.e_chk = chk; x.e_sd = sd;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic c, input logic f,
                       input logic h, input logic r);
    bus.host_valid = v; bus.host_data = d; bus.host_commit = c;
    bus.host_flush = f; bus.host_hold = h; bus.stream_ready = r;
  endtask

  task automatic check_idle_state(input string tag, input logic sv);
    check({tag, " stream_valid"}, 32'(bus.stream_valid), 32'(sv));
    check({tag, " stream_empty"}, 32'(bus.stream_empty), 32'd1);
    check({tag, " staged_count"}, 32'(bus.staged_count), 32'd0);
    check({tag, " committed_count"}, 32'(bus.committed_count), 32'd0);
    check({tag, " consumed_total"}, bus.consumed_total, 32'd0);
    check({tag, " host_ready"}, 32'(bus.host_ready), 32'd1);
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst = 1'b1;
    drive(0, 8'h00, 0, 0, 0, 0);

    // Expected values are the outputs in the cycle the inputs are applied,
    // before the edge that acts on them.
    //                v  d      c  f  h  r   hr stg cm cons sv se chk sd
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 0, 0,  1, 1, 0, 8'h00)); // 0 ready while empty
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 8'h00)); // 2 push without commit
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0,  1, 1, 0, 0,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 0,  1, 2, 0, 0,  1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 3, 0, 0,  1, 1, 0, 8'h00));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 3, 0, 0,  1, 1, 0, 8'h00)); // 6 commit
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 3, 3, 0,  1, 0, 1, 8'h11));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 3, 3, 0,  1, 0, 1, 8'h11)); // 8 pops
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 2, 2, 1,  1, 0, 1, 8'h22));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 1, 1, 2,  1, 0, 1, 8'h33));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 3,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'hAA, 1, 0, 0, 0,  1, 0, 0, 3,  1, 1, 0, 8'h00)); // 12 push+commit
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 1, 1, 3,  1, 0, 1, 8'hAA));
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0,  1, 0, 0, 4,  1, 1, 0, 8'h00)); // 14 fill to full
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 0,  1, 1, 0, 4,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 0,  1, 2, 0, 4,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0, 0,  1, 3, 0, 4,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'h05, 1, 0, 0, 0,  0, 4, 0, 4,  1, 1, 0, 8'h00)); // 18 full, push refused
    vecs.push_back(mk(1, 8'h05, 0, 0, 0, 1,  0, 4, 4, 4,  1, 0, 1, 8'h01)); // 19 pop does not free yet
    vecs.push_back(mk(1, 8'h05, 1, 0, 0, 1,  1, 3, 3, 5,  1, 0, 1, 8'h02)); // 20 streaming across wrap
    vecs.push_back(mk(1, 8'h06, 1, 0, 0, 1,  1, 3, 3, 6,  1, 0, 1, 8'h03));
    vecs.push_back(mk(1, 8'h07, 1, 0, 0, 1,  1, 3, 3, 7,  1, 0, 1, 8'h04));
    vecs.push_back(mk(1, 8'h08, 1, 0, 0, 1,  1, 3, 3, 8,  1, 0, 1, 8'h05));
    vecs.push_back(mk(1, 8'h09, 1, 0, 0, 1,  1, 3, 3, 9,  1, 0, 1, 8'h06));
    vecs.push_back(mk(1, 8'h0A, 1, 0, 0, 1,  1, 3, 3, 10, 1, 0, 1, 8'h07));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 3, 3, 11, 1, 0, 1, 8'h08));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 2, 2, 12, 1, 0, 1, 8'h09));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 1, 1, 13, 1, 0, 1, 8'h0A));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 14, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'hB1, 0, 0, 0, 0,  1, 0, 0, 14, 1, 1, 0, 8'h00)); // 30 flush scenario
    vecs.push_back(mk(1, 8'hB2, 1, 0, 0, 0,  1, 1, 0, 14, 1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'hB3, 0, 0, 0, 0,  1, 2, 2, 14, 1, 0, 1, 8'hB1));
    vecs.push_back(mk(1, 8'hB4, 1, 1, 0, 1,  0, 3, 2, 14, 1, 0, 1, 8'hB1)); // 33 flush+commit+pop
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 8'h00));
    vecs.push_back(mk(1, 8'hC1, 1, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 8'h00)); // 35 hold scenario
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 1, 1, 0,  1, 0, 1, 8'hC1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1,  1, 1, 1, 0,  0, 0, 1, 8'hC1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 1, 1, 0,  0, 0, 1, 8'hC1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 1, 1, 0,  1, 0, 1, 8'hC1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 1, 1, 0,  1, 0, 1, 8'hC1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 0, 0, 1,  1, 1, 0, 8'h00));

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_idle_state("reset", 1'b0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].f, vecs[i].h, vecs[i].r);
      #1;
      check($sformatf("v%0d host_ready", i), 32'(bus.host_ready), 32'(vecs[i].e_hr));
      check($sformatf("v%0d staged_count", i), 32'(bus.staged_count), 32'(vecs[i].e_stg));
      check($sformatf("v%0d committed_count", i), 32'(bus.committed_count), 32'(vecs[i].e_cm));
      check($sformatf("v%0d consumed_total", i), bus.consumed_total, vecs[i].e_cons);
      check($sformatf("v%0d stream_valid", i), 32'(bus.stream_valid), 32'(vecs[i].e_sv));
      check($sformatf("v%0d stream_empty", i), 32'(bus.stream_empty), 32'(vecs[i].e_se));
      if (vecs[i].e_chk)
        check($sformatf("v%0d stream_data", i), 32'(bus.stream_data), 32'(vecs[i].e_sd));
    end

    // mid-operation reset with committed data present
    @(negedge clk);
    drive(1, 8'hD1, 1, 0, 0, 0);
    @(negedge clk);
    drive(0, 8'h00, 0, 0, 0, 0);
    #1;
    check("pre_rst committed_count", 32'(bus.committed_count), 32'd1);
    check("pre_rst stream_data", 32'(bus.stream_data), 32'hD1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_state("mid_rst", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst stream_valid", 32'(bus.stream_valid), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
